// File: rtl/axi_bridge_pkg.sv
// Shared IDs, AR state encoding and AXI constants for the read side of the AXI bridge.
package axi_bridge_pkg;

    localparam logic [3:0] ID_INST = 4'd0;
    localparam logic [3:0] ID_DATA = 4'd1;

    typedef enum logic [1:0] {
        AR_IDLE  = 2'b01,
        AR_ISSUE = 2'b10
    } ar_state_t;

    localparam logic [7:0] AXI_LEN_SINGLE  = 8'd0;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_LOCK_NORMAL = 2'b00;
    localparam logic [3:0] AXI_CACHE_NONE  = 4'd0;
    localparam logic [2:0] AXI_PROT_NONE   = 3'd0;

    // SRAM-side size is log2 bytes; AXI arsize is the same value widened.
    function automatic logic [2:0] axi_size(input logic [1:0] size);
        return {1'b0, size};
    endfunction

endpackage

// File: rtl/rd_outstanding_cnt.sv
// Per-ID outstanding read counter; full blocks further grants so it never wraps.
module rd_outstanding_cnt #(
    parameter int unsigned MAX_OUT = 3
) (
    input  logic                           aclk,
    input  logic                           areset,
    input  logic                           inc,
    input  logic                           dec,
    output logic [$clog2(MAX_OUT+1)-1:0]   cnt,
    output logic                           full
);
    localparam int unsigned CNT_W = $clog2(MAX_OUT + 1);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            cnt_q <= '0;
        end else if (inc && !dec) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end else if (dec && !inc) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    assign cnt  = cnt_q;
    assign full = (cnt_q >= CNT_W'(MAX_OUT));

endmodule

// File: rtl/axi_rd_arbiter.sv
// Arbitrates inst/data SRAM-like read ports onto one AXI AR channel and routes R beats by rid.
module axi_rd_arbiter
    import axi_bridge_pkg::*;
#(
    parameter int unsigned MAX_OUT      = 3,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    input  logic [1:0]  inst_size,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic [31:0] data_addr,
    input  logic [1:0]  data_size,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    input  logic        wr_busy,
    input  logic [31:0] wr_addr,
    output logic [3:0]  arid,
    output logic [31:0] araddr,
    output logic [2:0]  arsize,
    output logic        arvalid,
    input  logic        arready,
    output logic [7:0]  arlen,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    input  logic [3:0]  rid,
    input  logic [31:0] rdata,
    input  logic        rvalid,
    input  logic        rlast,
    output logic        rready,
    output logic        rd_err
);
    localparam int unsigned CNT_W    = $clog2(MAX_OUT + 1);
    localparam int unsigned STARVE_W = $clog2(STARVE_LIMIT + 1);

    ar_state_t           state_q;
    logic [3:0]          id_q;
    logic [31:0]         addr_q;
    logic [1:0]          size_q;
    logic [STARVE_W-1:0] starve_q;

    logic [CNT_W-1:0] inst_cnt, data_cnt;
    logic             inst_full, data_full;
    logic             wr_hazard, inst_elig, data_elig, inst_wins;
    logic             grant_inst, grant_data;
    logic             inst_hit, data_hit, bad_beat;

    logic        inst_data_ok_q, data_data_ok_q, rd_err_q;
    logic [31:0] inst_rdata_q, data_rdata_q;

    // Single-beat bursts only, so rlast carries no information.
    logic unused_sigs;
    assign unused_sigs = ^{rlast, wr_addr[1:0]};

    // Word-granular hazard against the pending write.
    assign wr_hazard = wr_busy && (data_addr[31:2] == wr_addr[31:2]);
    assign inst_elig = inst_req && !inst_full;
    assign data_elig = data_req && !data_full && !wr_hazard;
    assign inst_wins = inst_elig &&
                       (!data_elig || (starve_q == STARVE_W'(STARVE_LIMIT)));

    assign grant_inst = (state_q == AR_IDLE) && inst_wins;
    assign grant_data = (state_q == AR_IDLE) && data_elig && !inst_wins;

    assign inst_addr_ok = grant_inst;
    assign data_addr_ok = grant_data;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q <= AR_IDLE;
            id_q    <= '0;
            addr_q  <= '0;
            size_q  <= '0;
        end else begin
            unique case (state_q)
                AR_IDLE: begin
                    if (grant_inst || grant_data) begin
                        state_q <= AR_ISSUE;
                        id_q    <= grant_inst ? ID_INST : ID_DATA;
                        addr_q  <= grant_inst ? inst_addr : data_addr;
                        size_q  <= grant_inst ? inst_size : data_size;
                    end
                end
                AR_ISSUE: begin
                    if (arready) state_q <= AR_IDLE;
                end
                default: state_q <= AR_IDLE;
            endcase
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            starve_q <= '0;
        end else if (grant_inst) begin
            starve_q <= '0;
        end else if (grant_data && inst_elig && (starve_q != STARVE_W'(STARVE_LIMIT))) begin
            starve_q <= starve_q + STARVE_W'(1);
        end
    end

    assign arvalid = (state_q == AR_ISSUE);
    assign arid    = id_q;
    assign araddr  = addr_q;
    assign arsize  = axi_size(size_q);
    assign arlen   = AXI_LEN_SINGLE;
    assign arburst = AXI_BURST_INCR;
    assign arlock  = AXI_LOCK_NORMAL;
    assign arcache = AXI_CACHE_NONE;
    assign arprot  = AXI_PROT_NONE;

    // A beat is only accepted for an ID that actually has a read in flight.
    assign inst_hit = rvalid && (rid == ID_INST) && (inst_cnt != '0);
    assign data_hit = rvalid && (rid == ID_DATA) && (data_cnt != '0);
    assign bad_beat = rvalid && !inst_hit && !data_hit;

    rd_outstanding_cnt #(.MAX_OUT(MAX_OUT)) u_inst_cnt (
        .aclk   (aclk),
        .areset (areset),
        .inc    (grant_inst),
        .dec    (inst_hit),
        .cnt    (inst_cnt),
        .full   (inst_full)
    );

    rd_outstanding_cnt #(.MAX_OUT(MAX_OUT)) u_data_cnt (
        .aclk   (aclk),
        .areset (areset),
        .inc    (grant_data),
        .dec    (data_hit),
        .cnt    (data_cnt),
        .full   (data_full)
    );

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            inst_data_ok_q <= 1'b0;
            data_data_ok_q <= 1'b0;
            inst_rdata_q   <= '0;
            data_rdata_q   <= '0;
            rd_err_q       <= 1'b0;
        end else begin
            inst_data_ok_q <= inst_hit;
            data_data_ok_q <= data_hit;
            if (inst_hit) inst_rdata_q <= rdata;
            if (data_hit) data_rdata_q <= rdata;
            if (bad_beat) rd_err_q <= 1'b1;
        end
    end

    assign rready       = 1'b1;
    assign inst_data_ok = inst_data_ok_q;
    assign data_data_ok = data_data_ok_q;
    assign inst_rdata   = inst_rdata_q;
    assign data_rdata   = data_rdata_q;
    assign rd_err       = rd_err_q;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Randomized bench for axi_rd_arbiter: a transaction-level model feeds scoreboard queues.
module tb_axi_rd_arbiter;

    localparam int MAX_OUT      = 3;
    localparam int STARVE_LIMIT = 4;

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic        inst_req = 1'b0, data_req = 1'b0;
    logic [31:0] inst_addr = '0, data_addr = '0;
    logic [1:0]  inst_size = '0, data_size = '0;
    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic [31:0] inst_rdata, data_rdata;
    logic        wr_busy = 1'b0;
    logic [31:0] wr_addr = '0;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [2:0]  arsize;
    logic        arvalid;
    logic        arready = 1'b0;
    logic [7:0]  arlen;
    logic [1:0]  arburst, arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic [3:0]  rid = '0;
    logic [31:0] rdata = '0;
    logic        rvalid = 1'b0;
    logic        rready, rd_err;

    axi_rd_arbiter #(.MAX_OUT(MAX_OUT), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .aclk(aclk), .areset(areset),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_size(inst_size),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_addr(data_addr), .data_size(data_size),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .wr_busy(wr_busy), .wr_addr(wr_addr),
        .arid(arid), .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
        .arlen(arlen), .arburst(arburst), .arlock(arlock), .arcache(arcache), .arprot(arprot),
        .rid(rid), .rdata(rdata), .rvalid(rvalid), .rlast(1'b1), .rready(rready),
        .rd_err(rd_err)
    );

    always #5 aclk = ~aclk;

    typedef struct { int grant; bit arv; bit err; } cyc_t;   // grant: 0 none, 1 inst, 2 data
    typedef struct { logic [3:0] id; logic [31:0] addr; logic [2:0] size; } ar_t;
    typedef struct { int id; logic [31:0] data; int due; } r_t;

    cyc_t cyc_q[$];
    ar_t  ar_q[$];
    r_t   r_q[$];

    int m_cnt[2];
    bit m_pend, m_err;
    int m_starve;
    bit inst_done, data_done;

    int n_chk = 0, n_pass = 0;
    int cyc_no = 0;
    bit mon_en = 1'b0;

    always @(posedge aclk) cyc_no <= cyc_no + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    endtask

    // Monitor: pops expectations whenever the DUT presents a response.
    always @(negedge aclk) begin
        cyc_t c;
        ar_t  a;
        r_t   r;
        if (mon_en) begin
            if (cyc_q.size() > 0) begin
                c = cyc_q.pop_front();
                check("inst_addr_ok", 32'(inst_addr_ok), 32'(c.grant == 1));
                check("data_addr_ok", 32'(data_addr_ok), 32'(c.grant == 2));
                check("arvalid", 32'(arvalid), 32'(c.arv));
                check("rd_err", 32'(rd_err), 32'(c.err));
                check("rready", 32'(rready), 32'd1);
            end
            if (arvalid && arready) begin
                if (ar_q.size() == 0) begin
                    check("ar_unexpected", 32'd1, 32'd0);
                end else begin
                    a = ar_q.pop_front();
                    check("arid", 32'(arid), 32'(a.id));
                    check("araddr", araddr, a.addr);
                    check("arsize", 32'(arsize), 32'(a.size));
                end
            end
            if (r_q.size() > 0 && r_q[0].due == cyc_no) begin
                r = r_q.pop_front();
                check("inst_data_ok", 32'(inst_data_ok), 32'(r.id == 0));
                check("data_data_ok", 32'(data_data_ok), 32'(r.id == 1));
                check(r.id == 0 ? "inst_rdata" : "data_rdata",
                      r.id == 0 ? inst_rdata : data_rdata, r.data);
            end else if (inst_data_ok || data_data_ok) begin
                check("data_ok_unexpected", {30'd0, inst_data_ok, data_data_ok}, 32'd0);
            end
        end
    end

    task automatic model_reset();
        m_cnt[0] = 0; m_cnt[1] = 0;
        m_pend = 0; m_err = 0; m_starve = 0;
        inst_done = 0; data_done = 0;
        cyc_q.delete(); ar_q.delete(); r_q.delete();
    endtask

    // One stimulus cycle per iteration; the model decides this cycle's outcome.
    task automatic run_phase(input int ncyc, input int req_pct, input int r_pct,
                             input int bad_pct, input int wr_pct, input int hit_pct,
                             input int ar_pct);
        bit   ei, ed;
        int   g, r;
        cyc_t c;
        ar_t  a;
        r_t   rb;
        for (int n = 0; n < ncyc; n++) begin
            @(posedge aclk);
            #1;
            if (inst_done) inst_req = 1'b0;
            if (data_done) data_req = 1'b0;
            inst_done = 0; data_done = 0;
            if (!inst_req && ($urandom % 100) < req_pct) begin
                inst_req  = 1'b1;
                inst_addr = $urandom;
                inst_size = 2'($urandom_range(2, 0));
            end
            if (!data_req && ($urandom % 100) < req_pct) begin
                data_req  = 1'b1;
                data_addr = $urandom;
                data_size = 2'($urandom_range(2, 0));
            end
            wr_busy = (($urandom % 100) < wr_pct);
            if (($urandom % 100) < hit_pct) wr_addr = {data_addr[31:2], 2'($urandom)};
            else wr_addr = $urandom;
            arready = (($urandom % 100) < ar_pct);
            rvalid  = 1'b0;
            rdata   = $urandom;
            if (($urandom % 100) < r_pct) begin
                if (($urandom % 100) < bad_pct) begin
                    rvalid = 1'b1;
                    if ($urandom % 2) rid = 4'($urandom_range(15, 2));
                    else if (m_cnt[0] == 0) rid = 4'd0;
                    else if (m_cnt[1] == 0) rid = 4'd1;
                    else rid = 4'd9;
                end else if (m_cnt[0] > 0 || m_cnt[1] > 0) begin
                    rvalid = 1'b1;
                    if (m_cnt[0] == 0) rid = 4'd1;
                    else if (m_cnt[1] == 0) rid = 4'd0;
                    else rid = 4'($urandom % 2);
                end
            end

            ei = inst_req && m_cnt[0] < MAX_OUT;
            ed = data_req && m_cnt[1] < MAX_OUT &&
                 !(wr_busy && (data_addr >> 2) == (wr_addr >> 2));
            g = 0;
            if (!m_pend) begin
                if (ei && (!ed || m_starve == STARVE_LIMIT)) g = 1;
                else if (ed) g = 2;
            end
            c.grant = g; c.arv = m_pend; c.err = m_err;
            cyc_q.push_back(c);

            if (m_pend && arready) m_pend = 0;
            if (g == 1) begin
                a.id = 4'd0; a.addr = inst_addr; a.size = {1'b0, inst_size};
                ar_q.push_back(a);
                m_pend = 1; inst_done = 1; m_starve = 0;
            end else if (g == 2) begin
                a.id = 4'd1; a.addr = data_addr; a.size = {1'b0, data_size};
                ar_q.push_back(a);
                m_pend = 1; data_done = 1;
                if (ei && m_starve < STARVE_LIMIT) m_starve++;
            end
            if (rvalid) begin
                r = int'(rid);
                if (r < 2 && m_cnt[r] > 0) begin
                    rb.id = r; rb.data = rdata; rb.due = cyc_no + 1;
                    r_q.push_back(rb);
                    m_cnt[r]--;
                end else begin
                    m_err = 1;
                end
            end
            if (g != 0) m_cnt[g-1]++;
        end
    endtask

    task automatic drain_and_check();
        run_phase(60, 0, 70, 0, 0, 0, 100);
        @(negedge aclk);
        #1;
        check("ar_queue_drained", 32'(ar_q.size()), 32'd0);
        check("r_queue_drained", 32'(r_q.size()), 32'd0);
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge aclk);
        #3;
        check("reset_arvalid", 32'(arvalid), 32'd0);
        check("reset_addr_ok", {30'd0, inst_addr_ok, data_addr_ok}, 32'd0);
        check("reset_data_ok", {30'd0, inst_data_ok, data_data_ok}, 32'd0);
        check("reset_inst_rdata", inst_rdata, 32'd0);
        check("reset_data_rdata", data_rdata, 32'd0);
        check("reset_rd_err", 32'(rd_err), 32'd0);
        check("tie_arlen", 32'(arlen), 32'd0);
        check("tie_arburst", 32'(arburst), 32'd1);
        check("tie_arlock", 32'(arlock), 32'd0);
        check("tie_arcache", 32'(arcache), 32'd0);
        check("tie_arprot", 32'(arprot), 32'd0);
        @(negedge aclk);
        areset = 1'b0;
        mon_en = 1'b1;

        run_phase(400, 70, 40, 0, 40, 50, 70);   // mixed traffic
        run_phase(300, 90, 10, 0, 30, 50, 90);   // scarce R beats: counters saturate
        run_phase(300, 100, 80, 0, 0, 0, 100);   // both always requesting: starvation
        drain_and_check();
        run_phase(200, 70, 50, 15, 40, 60, 60);  // stray rids
        drain_and_check();

        // Leave an AR stalled in ISSUE with a beat in flight, then reset asynchronously.
        run_phase(2, 100, 0, 0, 0, 0, 0);
        run_phase(1, 0, 100, 0, 0, 0, 0);
        @(negedge aclk);
        #1;
        mon_en = 1'b0;
        areset = 1'b1;
        #1;
        check("rst_mid_arvalid", 32'(arvalid), 32'd0);
        check("rst_mid_rd_err", 32'(rd_err), 32'd0);
        check("rst_mid_data_ok", {30'd0, inst_data_ok, data_data_ok}, 32'd0);
        inst_req = 1'b0; data_req = 1'b0; rvalid = 1'b0;
        @(posedge aclk);
        #1;
        check("rst_hold_data_ok", {30'd0, inst_data_ok, data_data_ok}, 32'd0);
        model_reset();
        @(negedge aclk);
        areset = 1'b0;
        mon_en = 1'b1;
        run_phase(200, 80, 30, 0, 30, 50, 80);
        drain_and_check();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
